// File: rtl/exp_golomb_pkg.sv
// Shared definitions for the Exp-Golomb stream decoder: mode encodings,
// default parameter values and derived widths.
package exp_golomb_pkg;

    typedef enum logic [1:0] {
        MODE_RSVD = 2'b00,
        MODE_UE   = 2'b01,
        MODE_SE   = 2'b10,
        MODE_TE   = 2'b11
    } mode_e;

    localparam int WIN_W_DEF = 32;
    localparam int OUT_W_DEF = 16;

    // Consumed length can reach the full window, so it needs clog2(WIN_W+1) bits.
    function automatic int len_w_for(input int win_w);
        return $clog2(win_w + 1);
    endfunction

    // Longest prefix that both fits a full codeword in the window and a value in OUT_W bits.
    function automatic int lz_limit(input int win_w, input int out_w);
        int by_win;
        by_win = (win_w - 1) / 2;
        return (by_win < out_w - 1) ? by_win : out_w - 1;
    endfunction

    localparam int LEN_W_DEF = len_w_for(WIN_W_DEF);

endpackage

// File: rtl/expg_lzc.sv
// Leading-zero counter over the bitstream window (MSB first), with an
// all-zero flag; the count saturates at WIN_W when no bit is set.
module expg_lzc #(
    parameter int WIN_W = 32,
    parameter int CNT_W = $clog2(WIN_W + 1)
) (
    input  logic [WIN_W-1:0] bits,
    output logic [CNT_W-1:0] count,
    output logic             all_zero
);

    // Scanning upward lets the highest set bit overwrite any lower hit.
    always_comb begin
        count = CNT_W'(WIN_W);
        for (int i = 0; i < WIN_W; i++) begin
            if (bits[i]) begin
                count = CNT_W'(WIN_W - 1 - i);
            end
        end
    end

    assign all_zero = ~|bits;

endmodule

// File: rtl/exp_golomb_stream_decoder.sv
// Two-stage Exp-Golomb (ue/se/te) decoder with valid/ready handshakes,
// a result counter and a sticky error flag.
module exp_golomb_stream_decoder
    import exp_golomb_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int LEN_W = len_w_for(WIN_W)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIN_W-1:0] in_bits,
    input  logic [1:0]       in_mode,
    input  logic [2:0]       in_te_max,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic [LEN_W-1:0] out_len,
    output logic             out_err,
    output logic [15:0]      sym_cnt,
    output logic             err_sticky
);

    localparam int LIM = lz_limit(WIN_W, OUT_W);

    logic [LEN_W-1:0] lz_p0;
    logic             zero_p0;

    logic             vld_p1;
    logic [LEN_W-1:0] lz_p1;
    logic             zero_p1;
    logic [WIN_W-1:0] bits_p1;
    mode_e            mode_p1;
    logic [2:0]       te_max_p1;

    logic             vld_p2;
    logic [OUT_W-1:0] value_p2;
    logic [LEN_W-1:0] len_p2;
    logic             err_p2;

    logic                    adv;
    logic                    in_fire;
    logic                    out_fire;
    logic                    lz_bad;
    logic [WIN_W-1:0]        code_num;
    logic signed [OUT_W-1:0] dec_value;
    logic [LEN_W-1:0]        dec_len;
    logic                    dec_err;

    // codeNum = (leading one followed by lz info bits) - 1; only meaningful when lz is in range.
    function automatic logic [WIN_W-1:0] ue_code(input logic [WIN_W-1:0] bits,
                                                 input logic [LEN_W-1:0] lz);
        int sh;
        sh = WIN_W - 2 * int'(lz) - 1;
        if (sh < 0) begin
            return '0;
        end
        return (bits >> sh) - WIN_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] ue_len(input logic [LEN_W-1:0] lz);
        return LEN_W'(2 * int'(lz) + 1);
    endfunction

    // Odd codeNum maps to positive (k+1)/2, even to -(k/2).
    function automatic logic signed [OUT_W-1:0] se_map(input logic [WIN_W-1:0] k);
        logic signed [OUT_W-1:0] half;
        half = signed'(OUT_W'(k >> 1));
        if (k[0]) begin
            return half + signed'(OUT_W'(1));
        end
        return -half;
    endfunction

    expg_lzc #(
        .WIN_W (WIN_W),
        .CNT_W (LEN_W)
    ) u_lzc (
        .bits     (in_bits),
        .count    (lz_p0),
        .all_zero (zero_p0)
    );

    assign adv      = !vld_p2 || out_ready;
    assign in_ready = reset_n && !flush && (!vld_p1 || adv);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_p2 && out_ready && !flush;

    // ---- stage 1: window, mode and leading-zero count ----
    always_ff @(posedge clk) begin
        if (in_fire) begin
            bits_p1   <= in_bits;
            lz_p1     <= lz_p0;
            zero_p1   <= zero_p0;
            mode_p1   <= mode_e'(in_mode);
            te_max_p1 <= in_te_max;
        end
    end

    always_comb begin
        code_num  = ue_code(bits_p1, lz_p1);
        lz_bad    = zero_p1 || (lz_p1 > LEN_W'(LIM));
        dec_value = '0;
        dec_len   = '0;
        dec_err   = 1'b0;
        unique case (mode_p1)
            MODE_UE: begin
                dec_err   = lz_bad;
                dec_value = signed'(OUT_W'(code_num));
                dec_len   = ue_len(lz_p1);
            end
            MODE_SE: begin
                dec_err   = lz_bad;
                dec_value = se_map(code_num);
                dec_len   = ue_len(lz_p1);
            end
            MODE_TE: begin
                if (te_max_p1 == 3'd0) begin
                    dec_value = '0;
                    dec_len   = '0;
                end else if (te_max_p1 == 3'd1) begin
                    dec_value = signed'({{(OUT_W-1){1'b0}}, ~bits_p1[WIN_W-1]});
                    dec_len   = LEN_W'(1);
                end else begin
                    dec_err   = lz_bad || (code_num > WIN_W'(te_max_p1));
                    dec_value = signed'(OUT_W'(code_num));
                    dec_len   = ue_len(lz_p1);
                end
            end
            default: begin
                dec_err = 1'b1;
            end
        endcase
        if (dec_err) begin
            dec_value = '0;
            dec_len   = '0;
        end
    end

    // ---- stage 2: decoded result, handshake and statistics ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            value_p2   <= '0;
            len_p2     <= '0;
            err_p2     <= 1'b0;
            sym_cnt    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
            end else begin
                if (in_fire) begin
                    vld_p1 <= 1'b1;
                end else if (adv) begin
                    vld_p1 <= 1'b0;
                end
                if (adv) begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        value_p2 <= dec_value;
                        len_p2   <= dec_len;
                        err_p2   <= dec_err;
                    end
                end
            end
            if (out_fire) begin
                sym_cnt <= sym_cnt + 16'd1;
                if (err_p2) begin
                    err_sticky <= 1'b1;
                end
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_value = value_p2;
    assign out_len   = len_p2;
    assign out_err   = err_p2;

endmodule
